// File: rtl/maze_tile_renderer.sv
// Tile-map maze renderer: writable wall bitmap, 2-clock wall-pixel pipeline, sprite-box collision engine.
// Render never stalls (one pixel per clock); a query holds qry_ready low for 5 cycles and ignores qry_valid meanwhile.
module maze_tile_renderer #(
    parameter int          TILE_LOG2  = 3,
    parameter int          COLS       = 48,
    parameter int          ROWS       = 54,
    parameter int          OFFSET_H   = 274,
    parameter int          OFFSET_V   = 58,
    parameter int          HALF       = 10,
    parameter logic [11:0] WALL_COLOR = 12'h00F
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     bright,
    input  logic [9:0]               hCount,
    input  logic [9:0]               vCount,
    input  logic                     wr_en,
    input  logic [$clog2(COLS)-1:0]  wr_col,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic                     wr_data,
    input  logic                     qry_valid,
    output logic                     qry_ready,
    input  logic [9:0]               qry_x,
    input  logic [9:0]               qry_y,
    output logic                     qry_done,
    output logic                     qry_hit,
    output logic                     wallFill,
    output logic [11:0]              rgb
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic signed [10:0] FIELD_W = 11'(COLS << TILE_LOG2);
    localparam logic signed [10:0] FIELD_H = 11'(ROWS << TILE_LOG2);
    localparam logic signed [10:0] OFF_H   = 11'(OFFSET_H);
    localparam logic signed [10:0] OFF_V   = 11'(OFFSET_V);
    localparam logic signed [10:0] HALF_S  = 11'(HALF);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] C0   = 3'd1;
    localparam logic [2:0] C1   = 3'd2;
    localparam logic [2:0] C2   = 3'd3;
    localparam logic [2:0] C3   = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [COLS-1:0] mapBits [ROWS];

    // Out-of-range writes are dropped so they cannot alias onto another tile.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mapBits[r][c] <= (r == 0) || (r == ROWS - 1) || (c == 0) || (c == COLS - 1);
                end
            end
        end else if (wr_en && (32'(wr_col) < COLS) && (32'(wr_row) < ROWS)) begin
            mapBits[wr_row][wr_col] <= wr_data;
        end
    end

    logic signed [10:0] pixX, pixY;
    logic               pixIn;

    assign pixX  = $signed({1'b0, hCount}) - OFF_H;
    assign pixY  = $signed({1'b0, vCount}) - OFF_V;
    assign pixIn = !pixX[10] && (pixX < FIELD_W) && !pixY[10] && (pixY < FIELD_H);

    logic [COL_W-1:0] s1Col;
    logic [ROW_W-1:0] s1Row;
    logic             s1In;
    logic             s1Bright;
    logic             s1Wall;

    assign s1Wall = s1In && mapBits[s1Row][s1Col];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1Col    <= '0;
            s1Row    <= '0;
            s1In     <= 1'b0;
            s1Bright <= 1'b0;
            wallFill <= 1'b0;
            rgb      <= 12'h000;
        end else begin
            s1Col    <= pixX[TILE_LOG2 +: COL_W];
            s1Row    <= pixY[TILE_LOG2 +: ROW_W];
            s1In     <= pixIn;
            s1Bright <= bright;
            wallFill <= s1Wall;
            rgb      <= (s1Bright && s1Wall) ? WALL_COLOR : 12'h000;
        end
    end

    logic [2:0]         state;
    logic [9:0]         qx, qy;
    logic               acc;
    logic signed [10:0] qxS, qyS, cornerX, cornerY;
    logic               cornerIn, cornerBit;

    assign qxS = $signed({1'b0, qx});
    assign qyS = $signed({1'b0, qy});

    always_comb begin
        cornerX = qxS - HALF_S;
        cornerY = qyS - HALF_S;
        if (state == C1 || state == C3) cornerX = qxS + HALF_S;
        if (state == C2 || state == C3) cornerY = qyS + HALF_S;
    end

    // A corner off the field (negative included) counts as a wall hit.
    assign cornerIn  = !cornerX[10] && (cornerX < FIELD_W) && !cornerY[10] && (cornerY < FIELD_H);
    assign cornerBit = cornerIn ? mapBits[cornerY[TILE_LOG2 +: ROW_W]][cornerX[TILE_LOG2 +: COL_W]] : 1'b1;

    assign qry_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            qx       <= '0;
            qy       <= '0;
            acc      <= 1'b0;
            qry_done <= 1'b0;
            qry_hit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (qry_valid) begin
                        qx    <= qry_x;
                        qy    <= qry_y;
                        acc   <= 1'b0;
                        state <= C0;
                    end
                end
                C0: begin
                    acc   <= acc | cornerBit;
                    state <= C1;
                end
                C1: begin
                    acc   <= acc | cornerBit;
                    state <= C2;
                end
                C2: begin
                    acc   <= acc | cornerBit;
                    state <= C3;
                end
                C3: begin
                    qry_hit  <= acc | cornerBit;
                    qry_done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    qry_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Scoreboarded bench for maze_tile_renderer: random pixel and query stimulus against a tile-map reference model.
module tb_maze_tile_renderer;

    localparam int COLS = 48;
    localparam int ROWS = 54;
    localparam int TSZ  = 8;
    localparam int OH   = 274;
    localparam int OV   = 58;
    localparam int HALF = 10;
    localparam int FW   = COLS * TSZ;
    localparam int FH   = ROWS * TSZ;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bright = 1'b0;
    logic [9:0]  hCount = '0;
    logic [9:0]  vCount = '0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_col = '0;
    logic [5:0]  wr_row = '0;
    logic        wr_data = 1'b0;
    logic        qry_valid = 1'b0;
    logic        qry_ready;
    logic [9:0]  qry_x = '0;
    logic [9:0]  qry_y = '0;
    logic        qry_done;
    logic        qry_hit;
    logic        wallFill;
    logic [11:0] rgb;

    always #5 clk = ~clk;

    maze_tile_renderer dut (
        .clk(clk), .reset_n(reset_n), .bright(bright), .hCount(hCount), .vCount(vCount),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
        .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_x(qry_x), .qry_y(qry_y),
        .qry_done(qry_done), .qry_hit(qry_hit), .wallFill(wallFill), .rgb(rgb)
    );

    typedef struct { int due; logic wf; logic [11:0] rgb; } pixExp_t;
    typedef struct { int due; logic hit; } qryExp_t;

    pixExp_t rq[$];
    qryExp_t qq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busyUntil = -1;
    logic lastHit = 1'b0;
    bit   monOn = 1'b0;
    bit   mdl [ROWS][COLS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic void mdlReset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mdl[r][c] = (r == 0) || (r == ROWS - 1) || (c == 0) || (c == COLS - 1);
    endfunction

    function automatic void mdlWrite(input int c, input int r, input bit d);
        if (c < COLS && r < ROWS) mdl[r][c] = d;
    endfunction

    function automatic logic pixWall(input int h, input int v);
        int x = h - OH;
        int y = v - OV;
        if (x < 0 || x >= FW || y < 0 || y >= FH) return 1'b0;
        return mdl[y / TSZ][x / TSZ];
    endfunction

    function automatic logic qryHit(input int x, input int y);
        logic hit = 1'b0;
        int cx, cy;
        for (int k = 0; k < 4; k++) begin
            cx = (k % 2 == 0) ? x - HALF : x + HALF;
            cy = (k < 2) ? y - HALF : y + HALF;
            if (cx < 0 || cx >= FW || cy < 0 || cy >= FH) hit = 1'b1;
            else hit = hit | mdl[cy / TSZ][cx / TSZ];
        end
        return hit;
    endfunction

    // Render monitor: compares every pixel whose 2-clock latency has elapsed.
    always @(negedge clk) begin : rmon
        pixExp_t e;
        while (monOn && rq.size() > 0 && rq[0].due <= cyc) begin
            e = rq.pop_front();
            if (e.due < cyc) chk("pix_late", cyc, e.due);
            chk("wallFill", wallFill, e.wf);
            chk("rgb", rgb, e.rgb);
        end
    end

    // Query monitor: ready window, done pulse timing, hit value and hit hold.
    always @(negedge clk) begin : qmon
        qryExp_t e;
        if (monOn && reset_n) begin
            chk("qry_ready", qry_ready, cyc > busyUntil);
            if (qry_done === 1'b1) begin
                if (qq.size() == 0) chk("qry_done_unexpected", qry_done, 0);
                else begin
                    e = qq.pop_front();
                    chk("qry_done_time", cyc, e.due);
                    chk("qry_hit", qry_hit, e.hit);
                    lastHit = e.hit;
                end
            end else begin
                chk("qry_hit_hold", qry_hit, lastHit);
                if (qq.size() > 0 && qq[0].due < cyc) begin
                    e = qq.pop_front();
                    chk("qry_done_missing", qry_done, 1);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pix(input int h, input int v, input bit b);
        pixExp_t e;
        hCount = 10'(h);
        vCount = 10'(v);
        bright = b;
        e.due = cyc + 2;
        e.wf  = pixWall(h, v);
        e.rgb = (b && e.wf) ? 12'h00F : 12'h000;
        rq.push_back(e);
        step(1);
    endtask

    task automatic drain();
        int g = 0;
        while ((rq.size() > 0 || qq.size() > 0) && g < 50) begin
            step(1);
            g++;
        end
        if (g >= 50) chk("drain_timeout", rq.size() + qq.size(), 0);
    endtask

    task automatic wr(input int c, input int r, input bit d);
        drain();
        wr_en = 1'b1; wr_col = 6'(c); wr_row = 6'(r); wr_data = d;
        step(1);
        wr_en = 1'b0;
        mdlWrite(c, r, d);
    endtask

    task automatic query(input int x, input int y, input bit doWr, input int wc, input int wrr, input bit wd);
        qryExp_t e;
        int g = 0;
        qry_valid = 1'b1;
        while (!qry_ready && g < 20) begin
            qry_x = 10'($urandom);
            qry_y = 10'($urandom);
            step(1);
            g++;
        end
        if (g >= 20) begin
            chk("qry_ready_timeout", qry_ready, 1);
            qry_valid = 1'b0;
            return;
        end
        qry_x = 10'(x);
        qry_y = 10'(y);
        if (doWr) begin
            wr_en = 1'b1; wr_col = 6'(wc); wr_row = 6'(wrr); wr_data = wd;
            mdlWrite(wc, wrr, wd);
        end
        e.hit = qryHit(x, y);
        step(1);
        qry_valid = 1'b0;
        wr_en = 1'b0;
        qry_x = 10'($urandom);
        qry_y = 10'($urandom);
        e.due = cyc + 4;
        busyUntil = cyc + 4;
        qq.push_back(e);
    endtask

    task automatic gridScan();
        int xs[8] = '{-1, 0, 7, 8, 375, 376, 383, 384};
        int ys[8] = '{-1, 0, 7, 8, 423, 424, 431, 432};
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                pix(xs[i] + OH, ys[j] + OV, bit'($urandom_range(1, 0)));
    endtask

    task automatic tileScan();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pix(c * TSZ + int'($urandom_range(7, 0)) + OH, r * TSZ + int'($urandom_range(7, 0)) + OV,
                    bit'($urandom_range(1, 0)));
    endtask

    task automatic randScan(input int n);
        for (int i = 0; i < n; i++)
            pix(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)), bit'($urandom_range(1, 0)));
    endtask

    initial begin
        mdlReset();
        step(3);
        chk("rst_qry_ready", qry_ready, 1);
        chk("rst_qry_done", qry_done, 0);
        chk("rst_qry_hit", qry_hit, 0);
        chk("rst_wallFill", wallFill, 0);
        chk("rst_rgb", rgb, 0);
        reset_n = 1'b1;
        monOn = 1'b1;

        gridScan();
        tileScan();
        randScan(300);

        wr(10, 20, 1'b1);
        drain();
        for (int y = 158; y < 170; y++)
            for (int x = 78; x < 90; x++)
                pix(x + OH, y + OV, bit'((x + y) % 2));

        wr(48, 20, 1'b0);
        wr(50, 10, 1'b1);
        wr(10, 54, 1'b0);
        wr(63, 63, 1'b1);
        drain();
        tileScan();

        drain();
        query(200, 200, 0, 0, 0, 0); drain();
        query(12, 200, 0, 0, 0, 0);  drain();
        query(5, 200, 0, 0, 0, 0);   drain();
        wr(26, 26, 1'b1);
        query(200, 200, 0, 0, 0, 0); drain();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(2, 0) == 0)
                wr(int'($urandom_range(46, 1)), int'($urandom_range(52, 1)), bit'($urandom_range(1, 0)));
            query(int'($urandom_range(420, 0)), int'($urandom_range(460, 0)), 0, 0, 0, 0);
            drain();
        end

        for (int i = 0; i < 5; i++)
            query(int'($urandom_range(400, 0)), int'($urandom_range(440, 0)), 0, 0, 0, 0);
        drain();

        // Write and accept on the same edge: C0 must already see the cleared tile.
        wr(26, 26, 1'b1);
        drain();
        query(200, 200, 1, 26, 26, 1'b0); drain();
        tileScan();

        wr(26, 26, 1'b1);
        wr(20, 30, 1'b1);
        drain();
        query(200, 200, 0, 0, 0, 0);
        step(1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        busyUntil = cyc - 1;
        qq.delete();
        lastHit = 1'b0;
        mdlReset();
        step(8);
        tileScan();
        query(200, 200, 0, 0, 0, 0); drain();
        gridScan();
        drain();
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete, cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
